// File: rtl/load_pkg.sv
// load_pkg: shared definitions for the load unit.
// Holds the instruction field layout, completion status codes, the line-size
// helper and the controller state enum.
package load_pkg;

  // Instruction field layout (bit offsets and widths)
  localparam int OPC_LSB       = 0;
  localparam int OPC_W         = 6;
  localparam int BUF_ID_LSB    = 16;
  localparam int BUF_ID_W      = 16;
  localparam int BUF_START_LSB = 32;
  localparam int BUF_START_W   = 16;
  localparam int LINE_CNT_LSB  = 48;
  localparam int LINE_CNT_W    = 16;
  localparam int DRAM_LINE_LSB = 64;
  localparam int DRAM_LINE_W   = 32;

  localparam int BEAT_CNT_W = 16;

  // Completion status codes
  localparam logic [1:0] ST_OK          = 2'd0;
  localparam logic [1:0] ST_BAD_BUF     = 2'd1;
  localparam logic [1:0] ST_EARLY_TLAST = 2'd2;
  localparam logic [1:0] ST_NO_TLAST    = 2'd3;

  // Bytes per stream/buffer word for a given data width
  function automatic int line_bytes(input int data_w);
    return data_w / 8;
  endfunction

  localparam int LINE_BYTES = 512 / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RECV,
    S_WAIT_RD,
    S_DONE
  } load_state_e;

endpackage

// File: rtl/load_addr_gen.sv
// load_addr_gen: beat counter and buffer address generator for the load unit.
// Ports:
//   kernel_clk, kernel_rst  clock / async active-high reset
//   clear                   restart the beat count (new instruction accepted)
//   beat                    one stream beat accepted this cycle
//   buf_start, line_cnt     latched instruction fields
//   tlast                   stream tlast of the current beat
//   wr_addr                 buffer word address for the current beat (wraps)
//   last_beat               current beat is beat number line_cnt
//   early_tlast             tlast seen before the final beat
module load_addr_gen
  import load_pkg::*;
#(
  parameter int BUF_AW = 11
) (
  input  logic                  kernel_clk,
  input  logic                  kernel_rst,
  input  logic                  clear,
  input  logic                  beat,
  input  logic [BUF_START_W-1:0] buf_start,
  input  logic [BEAT_CNT_W-1:0] line_cnt,
  input  logic                  tlast,
  output logic [BUF_AW-1:0]     wr_addr,
  output logic                  last_beat,
  output logic                  early_tlast
);

  logic [BEAT_CNT_W-1:0] beat_idx;

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      beat_idx <= '0;
    end else if (clear) begin
      beat_idx <= '0;
    end else if (beat) begin
      beat_idx <= beat_idx + BEAT_CNT_W'(1);
    end
  end

  // Buffer address wraps modulo 2^BUF_AW without any flag
  assign wr_addr     = BUF_AW'(buf_start) + BUF_AW'(beat_idx);
  assign last_beat   = (beat_idx + BEAT_CNT_W'(1)) == line_cnt;
  assign early_tlast = tlast && !last_beat;

endmodule

// File: rtl/load_unit_mc.sv
// load_unit_mc: moves line_cnt lines from DRAM (via an AXI read master and an
// AXI-stream) into one of NUM_BUF on-chip buffers.
// Ports:
//   kernel_clk, kernel_rst        clock / async active-high reset
//   ap_start, ctrl_instruction,
//   ctrl_addr_offset              instruction handshake and DRAM base
//   busy, ap_done, status         progress and completion report
//   dram_xfer_start_addr/size,
//   read_start, read_done         AXI read master control
//   data_tvalid/tready/tlast/tdata incoming line stream
//   buf_wr_valid/addr/data        one-hot buffer write port
//
// state     | meaning
// S_IDLE    | waiting for ap_start
// S_ISSUE   | pulse read_start to the read master
// S_RECV    | accept stream beats and write them to the buffer
// S_WAIT_RD | wait for the read master to report completion
// S_DONE    | one-cycle ap_done with status
module load_unit_mc
  import load_pkg::*;
#(
  parameter int NUM_BUF = 4,
  parameter int DATA_W  = 512,
  parameter int ADDR_W  = 64,
  parameter int XFER_W  = 32,
  parameter int BUF_AW  = 11,
  parameter int INST_W  = 96
) (
  input  logic                kernel_clk,
  input  logic                kernel_rst,
  input  logic                ap_start,
  input  logic [ADDR_W-1:0]   ctrl_addr_offset,
  input  logic [INST_W-1:0]   ctrl_instruction,
  output logic                busy,
  output logic                ap_done,
  output logic [1:0]          status,
  output logic [ADDR_W-1:0]   dram_xfer_start_addr,
  output logic [XFER_W-1:0]   dram_xfer_size_in_bytes,
  output logic                read_start,
  input  logic                read_done,
  input  logic                data_tvalid,
  output logic                data_tready,
  input  logic                data_tlast,
  input  logic [DATA_W-1:0]   data_tdata,
  output logic [NUM_BUF-1:0]  buf_wr_valid,
  output logic [BUF_AW-1:0]   buf_wr_addr,
  output logic [DATA_W-1:0]   buf_wr_data
);

  localparam int                 LB       = line_bytes(DATA_W);
  localparam logic [ADDR_W-1:0]  LB_ADDR  = ADDR_W'(LB);
  localparam logic [XFER_W-1:0]  LB_XFER  = XFER_W'(LB);
  localparam logic [BUF_ID_W-1:0] NUM_BUF_L = BUF_ID_W'(NUM_BUF);

  load_state_e state, state_nxt;

  logic [BUF_ID_W-1:0]    in_buf_id, buf_id_q;
  logic [BUF_START_W-1:0] in_buf_start, buf_start_q;
  logic [LINE_CNT_W-1:0]  in_line_cnt, line_cnt_q;
  logic [DRAM_LINE_W-1:0] in_dram_line;
  logic                   rd_seen;
  logic [1:0]             status_q;
  logic                   accept, beat, bad_buf;
  logic                   last_beat, early_tlast;
  logic [BUF_AW-1:0]      wr_addr;
  logic                   unused_fields;

  assign in_buf_id    = ctrl_instruction[BUF_ID_LSB    +: BUF_ID_W];
  assign in_buf_start = ctrl_instruction[BUF_START_LSB +: BUF_START_W];
  assign in_line_cnt  = ctrl_instruction[LINE_CNT_LSB  +: LINE_CNT_W];
  assign in_dram_line = ctrl_instruction[DRAM_LINE_LSB +: DRAM_LINE_W];
  // opcode and reserved bits carry no meaning for this unit
  assign unused_fields = ^ctrl_instruction[BUF_ID_LSB-1:OPC_LSB];

  assign accept  = (state == S_IDLE) && ap_start;
  assign bad_buf = in_buf_id >= NUM_BUF_L;
  assign beat    = data_tvalid && data_tready;

  load_addr_gen #(
    .BUF_AW (BUF_AW)
  ) u_addr_gen (
    .kernel_clk  (kernel_clk),
    .kernel_rst  (kernel_rst),
    .clear       (accept),
    .beat        (beat),
    .buf_start   (buf_start_q),
    .line_cnt    (line_cnt_q),
    .tlast       (data_tlast),
    .wr_addr     (wr_addr),
    .last_beat   (last_beat),
    .early_tlast (early_tlast)
  );

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    ap_done     = 1'b0;
    read_start  = 1'b0;
    data_tready = 1'b0;
    case (state)
      S_IDLE: begin
        if (ap_start) begin
          state_nxt = (bad_buf || in_line_cnt == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy       = 1'b1;
        read_start = 1'b1;
        state_nxt  = S_RECV;
      end
      S_RECV: begin
        busy        = 1'b1;
        data_tready = 1'b1;
        if (beat && (last_beat || data_tlast)) begin
          state_nxt = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        busy = 1'b1;
        if (read_done || rd_seen) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ap_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign status = ap_done ? status_q : 2'd0;

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      buf_id_q                <= '0;
      buf_start_q             <= '0;
      line_cnt_q              <= '0;
      rd_seen                 <= 1'b0;
      status_q                <= ST_OK;
      dram_xfer_start_addr    <= '0;
      dram_xfer_size_in_bytes <= '0;
      buf_wr_valid            <= '0;
      buf_wr_addr             <= '0;
      buf_wr_data             <= '0;
    end else begin
      buf_wr_valid <= '0;
      if (accept) begin
        buf_id_q                <= in_buf_id;
        buf_start_q             <= in_buf_start;
        line_cnt_q              <= in_line_cnt;
        rd_seen                 <= 1'b0;
        status_q                <= bad_buf ? ST_BAD_BUF : ST_OK;
        dram_xfer_start_addr    <= ctrl_addr_offset + ADDR_W'(in_dram_line) * LB_ADDR;
        dram_xfer_size_in_bytes <= XFER_W'(in_line_cnt) * LB_XFER;
      end else if (busy && read_done) begin
        // read master may finish before the last beat is consumed
        rd_seen <= 1'b1;
      end
      if (beat) begin
        buf_wr_valid <= NUM_BUF'(1) << buf_id_q;
        buf_wr_addr  <= wr_addr;
        buf_wr_data  <= data_tdata;
        if (last_beat && !data_tlast) begin
          status_q <= ST_NO_TLAST;
        end else if (early_tlast) begin
          status_q <= ST_EARLY_TLAST;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_unit_mc.sv
module tb_load_unit_mc;
  localparam int NUM_BUF = 4;
  localparam int DATA_W  = 512;
  localparam int ADDR_W  = 64;
  localparam int XFER_W  = 32;
  localparam int BUF_AW  = 11;
  localparam int INST_W  = 96;

  logic                kernel_clk = 1'b0;
  logic                kernel_rst = 1'b1;
  logic                ap_start;
  logic [ADDR_W-1:0]   ctrl_addr_offset;
  logic [INST_W-1:0]   ctrl_instruction;
  logic                busy, ap_done;
  logic [1:0]          status;
  logic [ADDR_W-1:0]   dram_xfer_start_addr;
  logic [XFER_W-1:0]   dram_xfer_size_in_bytes;
  logic                read_start, read_done;
  logic                data_tvalid, data_tready, data_tlast;
  logic [DATA_W-1:0]   data_tdata;
  logic [NUM_BUF-1:0]  buf_wr_valid;
  logic [BUF_AW-1:0]   buf_wr_addr;
  logic [DATA_W-1:0]   buf_wr_data;

  always #5 kernel_clk = ~kernel_clk;

  load_unit_mc #(
    .NUM_BUF(NUM_BUF), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .XFER_W(XFER_W), .BUF_AW(BUF_AW), .INST_W(INST_W)
  ) dut (
    .kernel_clk              (kernel_clk),
    .kernel_rst              (kernel_rst),
    .ap_start                (ap_start),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_instruction        (ctrl_instruction),
    .busy                    (busy),
    .ap_done                 (ap_done),
    .status                  (status),
    .dram_xfer_start_addr    (dram_xfer_start_addr),
    .dram_xfer_size_in_bytes (dram_xfer_size_in_bytes),
    .read_start              (read_start),
    .read_done               (read_done),
    .data_tvalid             (data_tvalid),
    .data_tready             (data_tready),
    .data_tlast              (data_tlast),
    .data_tdata              (data_tdata),
    .buf_wr_valid            (buf_wr_valid),
    .buf_wr_addr             (buf_wr_addr),
    .buf_wr_data             (buf_wr_data)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic [NUM_BUF-1:0] v;
    logic [BUF_AW-1:0]  a;
    logic [DATA_W-1:0]  d;
  } wr_t;

  // reference expectations for the transaction in progress
  wr_t                exp_wr[$];
  logic [ADDR_W-1:0]  exp_addr;
  logic [XFER_W-1:0]  exp_size;
  logic [1:0]         exp_status;

  int                 rs_count = 0;
  int                 done_count = 0;
  logic [ADDR_W-1:0]  last_rs_addr;
  logic [XFER_W-1:0]  last_rs_size;
  logic [1:0]         last_status;
  int                 wr_addr_log[$];
  wr_t                mon_e;

  always @(negedge kernel_clk) begin
    if (!kernel_rst) begin
      if (buf_wr_valid != '0) begin
        wr_addr_log.push_back(int'(buf_wr_addr));
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 512'(buf_wr_valid), 512'd0);
        end else begin
          mon_e = exp_wr.pop_front();
          check("wr_valid", 512'(buf_wr_valid), 512'(mon_e.v));
          check("wr_addr", 512'(buf_wr_addr), 512'(mon_e.a));
          check("wr_data", buf_wr_data, mon_e.d);
        end
      end
      if (read_start) begin
        rs_count++;
        last_rs_addr = dram_xfer_start_addr;
        last_rs_size = dram_xfer_size_in_bytes;
        check("rs_addr", 512'(dram_xfer_start_addr), 512'(exp_addr));
        check("rs_size", 512'(dram_xfer_size_in_bytes), 512'(exp_size));
      end
      if (ap_done) begin
        done_count++;
        last_status = status;
        check("status", 512'(status), 512'(exp_status));
        check("busy_at_done", 512'(busy), 512'd0);
        check("done_addr", 512'(dram_xfer_start_addr), 512'(exp_addr));
        check("done_size", 512'(dram_xfer_size_in_bytes), 512'(exp_size));
      end
      if (!busy) check("tready_not_busy", 512'(data_tready), 512'd0);
    end
  end

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // tpos: 1-based beat carrying tlast (0 = none); mode 1 toggles tvalid,
  // mode 2 also fires a stray ap_start while busy
  task automatic run_txn(input logic [15:0] bid, input logic [15:0] bstart,
                         input logic [15:0] lc, input logic [31:0] dline,
                         input logic [63:0] off, input int tpos,
                         input int mode, input int rd_delay);
    int n, rs0, d0, cyc;
    bit has_read;
    logic [1:0] st;
    wr_t w;
    logic [DATA_W-1:0] beats[$];
    logic [DATA_W-1:0] d;

    has_read = (int'(bid) < NUM_BUF) && (lc != 0);
    if (int'(bid) >= NUM_BUF)            st = 2'd1;
    else if (lc == 0)                    st = 2'd0;
    else if (tpos >= 1 && tpos < int'(lc)) st = 2'd2;
    else if (tpos == int'(lc))           st = 2'd0;
    else                                 st = 2'd3;
    n = !has_read ? 0 : ((st == 2'd2) ? tpos : int'(lc));

    exp_addr   = off + 64'(dline) * 64'd64;
    exp_size   = 32'(lc) * 32'd64;
    exp_status = st;
    wr_addr_log.delete();
    for (int i = 0; i < n; i++) begin
      d = rand_line();
      beats.push_back(d);
      w.v = NUM_BUF'(1) << bid;
      w.a = BUF_AW'((int'(bstart) + i) % (1 << BUF_AW));
      w.d = d;
      exp_wr.push_back(w);
    end
    rs0 = rs_count;
    d0  = done_count;

    ap_start         = 1'b1;
    ctrl_instruction = {dline, lc, bstart, bid, 16'($urandom)};
    ctrl_addr_offset = off;
    @(negedge kernel_clk);
    ap_start         = 1'b0;
    ctrl_instruction = {$urandom, $urandom, $urandom};
    ctrl_addr_offset = {$urandom, $urandom};
    check("busy_after_accept", 512'(busy), 512'(has_read));

    fork
      begin
        int i, c;
        bit tv, ph;
        i = 0; c = 0; ph = 1'b0;
        while (i < n && c < 4000) begin
          tv = (mode == 1) ? ph : ($urandom_range(0, 3) != 0);
          ph = !ph;
          data_tvalid = tv;
          data_tdata  = tv ? beats[i] : rand_line();
          data_tlast  = tv ? (i + 1 == tpos) : 1'($urandom_range(0, 1));
          if (tv && data_tready) i++;
          @(negedge kernel_clk);
          c++;
        end
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
        if (i < n) check("stream_timeout", 512'(i), 512'(n));
      end
      begin
        int c;
        c = 0;
        if (has_read) begin
          while (!read_start && c < 100) begin
            @(negedge kernel_clk);
            c++;
          end
          check("read_start_seen", 512'(read_start), 512'd1);
          if (mode == 2) begin
            ap_start         = 1'b1;
            ctrl_instruction = {$urandom, $urandom, $urandom};
            @(negedge kernel_clk);
            ap_start = 1'b0;
          end
          repeat (rd_delay) @(negedge kernel_clk);
          read_done = 1'b1;
          @(negedge kernel_clk);
          read_done = 1'b0;
        end
      end
    join

    cyc = 0;
    while (!ap_done && cyc < 4000) begin
      @(negedge kernel_clk);
      cyc++;
    end
    if (!ap_done) check("ap_done_timeout", 512'(ap_done), 512'd1);
    @(negedge kernel_clk);
    check("writes_left", 512'(exp_wr.size()), 512'd0);
    exp_wr.delete();
    check("read_start_count", 512'(rs_count - rs0), 512'(has_read));
    check("done_count", 512'(done_count - d0), 512'd1);
    check("busy_after_done", 512'(busy), 512'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 512'(busy), 512'd0);
    check({tag, "_ap_done"}, 512'(ap_done), 512'd0);
    check({tag, "_status"}, 512'(status), 512'd0);
    check({tag, "_read_start"}, 512'(read_start), 512'd0);
    check({tag, "_tready"}, 512'(data_tready), 512'd0);
    check({tag, "_wr_valid"}, 512'(buf_wr_valid), 512'd0);
    check({tag, "_wr_addr"}, 512'(buf_wr_addr), 512'd0);
    check({tag, "_wr_data"}, buf_wr_data, 512'd0);
    check({tag, "_xfer_addr"}, 512'(dram_xfer_start_addr), 512'd0);
    check({tag, "_xfer_size"}, 512'(dram_xfer_size_in_bytes), 512'd0);
  endtask

  task automatic reset_test();
    int i, c, d0;
    logic [DATA_W-1:0] d;
    wr_t w;
    exp_addr   = 64'd0;
    exp_size   = 32'd512;
    exp_status = 2'd0;
    d0 = done_count;
    ap_start         = 1'b1;
    ctrl_instruction = {32'd0, 16'd8, 16'd100, 16'd1, 16'd0};
    ctrl_addr_offset = 64'd0;
    @(negedge kernel_clk);
    ap_start = 1'b0;
    i = 0; c = 0;
    while (i < 3 && c < 100) begin
      d = rand_line();
      data_tvalid = 1'b1;
      data_tdata  = d;
      data_tlast  = 1'b0;
      if (data_tready) begin
        w.v = NUM_BUF'(2);
        w.a = BUF_AW'(100 + i);
        w.d = d;
        exp_wr.push_back(w);
        i++;
      end
      @(negedge kernel_clk);
      c++;
    end
    // beat 4 is on the bus when reset hits and must never be written
    data_tdata = rand_line();
    #1 kernel_rst = 1'b1;
    @(negedge kernel_clk);
    check_all_zero("mid_reset");
    data_tvalid = 1'b0;
    @(negedge kernel_clk);
    kernel_rst = 1'b0;
    repeat (3) @(negedge kernel_clk);
    check("reset_writes_left", 512'(exp_wr.size()), 512'd0);
    exp_wr.delete();
    check("reset_no_done", 512'(done_count - d0), 512'd0);
    run_txn(16'd2, 16'd5, 16'd1, 32'd3, 64'h40, 1, 0, 2);
    check("post_reset_status", 512'(last_status), 512'd0);
    check("post_reset_nwr", 512'(wr_addr_log.size()), 512'd1);
  endtask

  initial begin
    logic [15:0] bid, lc;
    ap_start = 1'b0; ctrl_addr_offset = '0; ctrl_instruction = '0;
    read_done = 1'b0; data_tvalid = 1'b0; data_tlast = 1'b0; data_tdata = '0;
    kernel_rst = 1'b1;
    repeat (3) @(negedge kernel_clk);
    check_all_zero("reset");
    kernel_rst = 1'b0;
    @(negedge kernel_clk);

    data_tvalid = 1'b1;
    data_tdata  = rand_line();
    repeat (5) @(negedge kernel_clk);
    check("idle_tready", 512'(data_tready), 512'd0);
    data_tvalid = 1'b0;

    run_txn(16'd0, 16'd0, 16'd2, 32'd0, 64'd0, 2, 0, 3);
    check("basic_addr", 512'(last_rs_addr), 512'd0);
    check("basic_size", 512'(last_rs_size), 512'd128);
    check("basic_nwr", 512'(wr_addr_log.size()), 512'd2);
    check("basic_a1", 512'(wr_addr_log[1]), 512'd1);
    check("basic_status", 512'(last_status), 512'd0);

    run_txn(16'd3, 16'd2040, 16'd16, 32'd12, 64'h1000, 16, 0, 5);
    check("wrap_addr", 512'(last_rs_addr), 512'h1300);
    check("wrap_size", 512'(last_rs_size), 512'd1024);
    check("wrap_a0", 512'(wr_addr_log[0]), 512'd2040);
    check("wrap_a7", 512'(wr_addr_log[7]), 512'd2047);
    check("wrap_a8", 512'(wr_addr_log[8]), 512'd0);
    check("wrap_a15", 512'(wr_addr_log[15]), 512'd7);

    run_txn(16'd1, 16'd10, 16'd4, 32'd5, 64'h20, 4, 1, 20);
    check("toggle_nwr", 512'(wr_addr_log.size()), 512'd4);
    check("toggle_status", 512'(last_status), 512'd0);

    run_txn(16'd2, 16'd0, 16'd4, 32'd0, 64'd0, 2, 0, 0);
    check("early_status", 512'(last_status), 512'd2);
    check("early_nwr", 512'(wr_addr_log.size()), 512'd2);

    run_txn(16'd7, 16'd0, 16'd4, 32'd0, 64'd0, 4, 0, 0);
    check("badbuf_status", 512'(last_status), 512'd1);

    run_txn(16'd1, 16'd0, 16'd0, 32'd9, 64'd0, 0, 0, 0);
    check("zero_len_status", 512'(last_status), 512'd0);

    run_txn(16'd0, 16'd7, 16'd3, 32'd1, 64'd0, 0, 2, 1);
    check("no_tlast_status", 512'(last_status), 512'd3);

    reset_test();

    for (int t = 0; t < 40; t++) begin
      bid = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(4, 15)) : 16'($urandom_range(0, 3));
      lc  = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      run_txn(bid, 16'($urandom), lc, $urandom, {$urandom, $urandom},
              $urandom_range(0, int'(lc) + 1), $urandom_range(0, 2), $urandom_range(0, 30));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
